// File: rtl/llc_set_table.sv
// Table of LLC sets in flight between the process and update stages.
// Allocation and lookup see registered state only; removal frees on the next edge.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module llc_set_table #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned PTR_BITS    = 3,
    parameter int unsigned SET_BITS    = `LLC_SET_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [SET_BITS-1:0] alloc_set,
    output logic                alloc_ready,
    output logic [PTR_BITS-1:0] alloc_ptr,
    input  logic [SET_BITS-1:0] lookup_set,
    output logic                lookup_hit,
    output logic [PTR_BITS-1:0] lookup_ptr,
    input  logic                remove_set_from_table,
    input  logic [PTR_BITS-1:0] table_pointer_to_remove,
    output logic [PTR_BITS:0]   occupancy,
    output logic                full,
    output logic                empty,
    output logic                remove_err
);

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [SET_BITS-1:0]    set_q [NUM_ENTRIES];
    logic [PTR_BITS:0]      occ_q;
    logic                   err_q;

    logic alloc_found;
    logic alloc_fire;
    logic remove_ok;

    assign occupancy   = occ_q;
    assign full        = (occ_q == FULL_COUNT);
    assign empty       = (occ_q == '0);
    assign alloc_ready = !full;
    assign remove_err  = err_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign remove_ok   = remove_set_from_table && valid_q[table_pointer_to_remove];

    // Lowest free index; only meaningful while not full.
    always_comb begin
        alloc_ptr   = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!alloc_found && !valid_q[i]) begin
                alloc_ptr   = PTR_BITS'(i);
                alloc_found = 1'b1;
            end
        end
    end

    // Entries being removed this cycle still hit, which keeps dispatch conservative.
    always_comb begin
        lookup_ptr = '0;
        lookup_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!lookup_hit && valid_q[i] && (set_q[i] == lookup_set)) begin
                lookup_ptr = PTR_BITS'(i);
                lookup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= remove_set_from_table && !valid_q[table_pointer_to_remove];
            // Alloc targets an invalid entry and a valid remove a valid one, so they never collide.
            if (alloc_fire) begin
                valid_q[alloc_ptr] <= 1'b1;
            end
            if (remove_ok) begin
                valid_q[table_pointer_to_remove] <= 1'b0;
            end
            if (alloc_fire && !remove_ok) begin
                occ_q <= occ_q + 1'b1;
            end else if (!alloc_fire && remove_ok) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    // Set field is don't-care while invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && alloc_fire) begin
            set_q[alloc_ptr] <= alloc_set;
        end
    end

endmodule

// File: tb/tb_llc_set_table.sv
// Scenario-driven bench for llc_set_table; expected status vectors are queued
// when stimulus is driven and compared when the DUT output is sampled.
module tb_llc_set_table;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_valid = 1'b0;
    logic [7:0] alloc_set = '0;
    logic       alloc_ready;
    logic [2:0] alloc_ptr;
    logic [7:0] lookup_set = '0;
    logic       lookup_hit;
    logic [2:0] lookup_ptr;
    logic       remove_set_from_table = 1'b0;
    logic [2:0] table_pointer_to_remove = '0;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       remove_err;

    int checks = 0;
    int errors = 0;
    logic [14:0] sb[$];
    logic [14:0] e;

    // Status layout: occ[14:11] full[10] empty[9] ready[8] aptr[7:5] hit[4] lptr[3:1] err[0]
    localparam logic [14:0] NO_APTR = 15'h7F1F;
    wire [14:0] st = {occupancy, full, empty, alloc_ready, alloc_ptr, lookup_hit, lookup_ptr, remove_err};

    llc_set_table #(
        .NUM_ENTRIES(8),
        .PTR_BITS(3),
        .SET_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_valid(alloc_valid),
        .alloc_set(alloc_set),
        .alloc_ready(alloc_ready),
        .alloc_ptr(alloc_ptr),
        .lookup_set(lookup_set),
        .lookup_hit(lookup_hit),
        .lookup_ptr(lookup_ptr),
        .remove_set_from_table(remove_set_from_table),
        .table_pointer_to_remove(table_pointer_to_remove),
        .occupancy(occupancy),
        .full(full),
        .empty(empty),
        .remove_err(remove_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pk(input int occ, input bit f, input bit em, input bit rdy,
                                       input int ap, input bit lh, input int lp, input bit re);
        return {4'(occ), f, em, rdy, 3'(ap), lh, 3'(lp), re};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alloc_valid = 1'b1; alloc_set = 8'h10;
        remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd2;
        sb.push_back(pk(0, 0, 1, 1, 0, 0, 0, 0));
        tick();
        rst = 1'b0; alloc_valid = 1'b0; remove_set_from_table = 1'b0; lookup_set = 8'h10;
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", st, e); end
    endtask

    task automatic test_alloc_basic();
        lookup_set = 8'h40;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_set = 8'(8'h10 * (i + 1));
            sb.push_back(pk(i, 0, i == 0, 1, i, 0, 0, 0));
            #1;
            e = sb.pop_front(); checks++;
            if (st !== e) begin errors++; $display("FAIL alloc_grant_%0d: got %h expected %h", i, st, e); end
            tick();
        end
        alloc_valid = 1'b0; lookup_set = 8'h20;
        sb.push_back(pk(3, 0, 0, 1, 3, 1, 1, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL lookup_hit_20: got %h expected %h", st, e); end
        lookup_set = 8'h40;
        sb.push_back(pk(3, 0, 0, 1, 3, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL lookup_miss_40: got %h expected %h", st, e); end
    endtask

    task automatic test_full();
        lookup_set = 8'h40;
        for (int i = 3; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_set = 8'(8'h80 + i);
            sb.push_back(pk(i, 0, 0, 1, i, 0, 0, 0));
            #1;
            e = sb.pop_front(); checks++;
            if (st !== e) begin errors++; $display("FAIL fill_grant_%0d: got %h expected %h", i, st, e); end
            tick();
        end
        alloc_set = 8'h99; lookup_set = 8'h99;
        for (int j = 0; j < 4; j++) begin
            sb.push_back(pk(8, 1, 0, 0, 0, 0, 0, 0));
            #1;
            e = sb.pop_front(); checks++;
            if ((st & NO_APTR) !== (e & NO_APTR)) begin
                errors++; $display("FAIL full_hold_%0d: got %h expected %h", j, st, e);
            end
            if (j < 3) tick();
        end
        alloc_valid = 1'b0; remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd5;
        lookup_set = 8'h85;
        sb.push_back(pk(8, 1, 0, 0, 0, 1, 5, 0));
        #1;
        e = sb.pop_front(); checks++;
        if ((st & NO_APTR) !== (e & NO_APTR)) begin errors++; $display("FAIL full_remove_cycle: got %h expected %h", st, e); end
        tick();
        remove_set_from_table = 1'b0;
        sb.push_back(pk(7, 0, 0, 1, 5, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL after_remove_5: got %h expected %h", st, e); end
        alloc_valid = 1'b1; alloc_set = 8'h85;
        sb.push_back(pk(8, 1, 0, 0, 0, 1, 5, 0));
        tick();
        alloc_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++;
        if ((st & NO_APTR) !== (e & NO_APTR)) begin errors++; $display("FAIL refill_5: got %h expected %h", st, e); end
    endtask

    task automatic test_full_remove_alloc();
        alloc_valid = 1'b1; alloc_set = 8'hA0;
        remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd0; lookup_set = 8'h10;
        sb.push_back(pk(8, 1, 0, 0, 0, 1, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if ((st & NO_APTR) !== (e & NO_APTR)) begin errors++; $display("FAIL full_remove_alloc_held: got %h expected %h", st, e); end
        tick();
        remove_set_from_table = 1'b0; lookup_set = 8'hA0;
        sb.push_back(pk(7, 0, 0, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL full_remove_next_grant: got %h expected %h", st, e); end
        sb.push_back(pk(8, 1, 0, 0, 0, 1, 0, 0));
        tick();
        alloc_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++;
        if ((st & NO_APTR) !== (e & NO_APTR)) begin errors++; $display("FAIL full_remove_refill: got %h expected %h", st, e); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_set = 8'(8'h10 * (i + 1));
            tick();
        end
        alloc_set = 8'h55; remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd1;
        lookup_set = 8'h20;
        sb.push_back(pk(3, 0, 0, 1, 3, 1, 1, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL simul_removed_still_hits: got %h expected %h", st, e); end
        tick();
        alloc_valid = 1'b0; remove_set_from_table = 1'b0; lookup_set = 8'h55;
        sb.push_back(pk(3, 0, 0, 1, 1, 1, 3, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL simul_entry3_55: got %h expected %h", st, e); end
        lookup_set = 8'h20;
        sb.push_back(pk(3, 0, 0, 1, 1, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL simul_entry1_freed: got %h expected %h", st, e); end
    endtask

    task automatic test_remove_err();
        remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd6; lookup_set = 8'h30;
        sb.push_back(pk(3, 0, 0, 1, 1, 1, 2, 1));
        sb.push_back(pk(3, 0, 0, 1, 1, 1, 2, 0));
        tick();
        remove_set_from_table = 1'b0;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL remove_err_pulse: got %h expected %h", st, e); end
        tick();
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL remove_err_clear: got %h expected %h", st, e); end
        remove_set_from_table = 1'b1; table_pointer_to_remove = 3'd1;
        alloc_valid = 1'b1; alloc_set = 8'h66; lookup_set = 8'h66;
        sb.push_back(pk(4, 0, 0, 1, 4, 1, 1, 1));
        sb.push_back(pk(4, 0, 0, 1, 4, 1, 1, 0));
        tick();
        remove_set_from_table = 1'b0; alloc_valid = 1'b0;
        #1;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL err_with_alloc: got %h expected %h", st, e); end
        tick();
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL err_with_alloc_clear: got %h expected %h", st, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] probes [5];
        probes = '{8'h10, 8'h66, 8'h30, 8'h55, 8'h77};
        alloc_valid = 1'b1; alloc_set = 8'h77; rst = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back(pk(0, 0, 1, 1, 0, 0, 0, 0));
        tick();
        rst = 1'b0; alloc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lookup_set = probes[i];
            #1;
            e = sb.pop_front(); checks++;
            if (st !== e) begin errors++; $display("FAIL reset_mid_probe_%0d: got %h expected %h", i, st, e); end
        end
        alloc_valid = 1'b1; alloc_set = 8'h77; lookup_set = 8'h77;
        sb.push_back(pk(1, 0, 0, 1, 1, 1, 0, 0));
        tick();
        alloc_valid = 1'b0;
        e = sb.pop_front(); checks++;
        if (st !== e) begin errors++; $display("FAIL post_reset_alloc: got %h expected %h", st, e); end
    endtask

    initial begin
        tick();
        test_reset();
        test_alloc_basic();
        test_full();
        test_full_remove_alloc();
        test_back_to_back();
        test_remove_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
